mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Memory-stage consumer of the EX->MEM pipe register and producer of the MEM->WB pipe register for the RV64I pipeline. It issues loads and stores to the data RAM over a req/gnt/rvalid handshake, extends load data by funct3, and stalls upstream while an access is outstanding. Non-memory instructions pass through in one cycle.

Parameters:
DATA_WIDTH, 64, datapath and address width
RF_SIZE, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_pc  in  64  EXMEM PC
ex_pc_next  in  64  EXMEM PC_Next
ex_alu_result  in  64  effective address, or result for non-memory ops
ex_store_data  in  64  rs2 value for stores
ex_rd  in  5  destination register (RegIdx[2])
ex_reg_wen  in  1  EXMEM Reg_WEn
ex_mem_ren  in  1  load
ex_mem_wen  in  1  store
ex_detail  in  3  funct3
ex_enable  in  1  EXMEM slot valid
stall_o  out  1  hold EXMEM and upstream stages
misalign_o  out  1  one-cycle pulse: misaligned access dropped
mem_req  out  1  RAM request
mem_we  out  1  RAM write
mem_addr  out  64  address of the 8-byte word (addr & ~7)
mem_wstrb  out  8  byte strobes
mem_wdata  out  64  store data shifted into lane position
mem_gnt  in  1  request accepted
mem_rvalid  in  1  response (read data or write ack)
mem_rdata  in  64  full 8-byte word
wb_pc, wb_pc_next  out  64 each  MEMWB PC fields
wb_rd  out  5  MEMWB RD_Addr
wb_reg_wen  out  1  MEMWB Reg_WEn
wb_mem_ren  out  1  MEMWB Mem_REn
wb_data  out  64  MEMWB WB_Data
wb_enable  out  1  MEMWB slot valid

Behaviour:
- Reset: state IDLE, all wb_* outputs 0, mem_req 0, misalign_o 0. Reset asynchronous; any access in flight is abandoned, and an rvalid arriving in IDLE is ignored.
- Memory op: ex_enable & (ex_mem_ren | ex_mem_wen). ren and wen never both set; wen wins if they are.
- Size from detail[1:0]: 0=B, 1=H, 2=W, 3=D. Load detail[2]=1 means zero-extend (LBU/LHU/LWU). Load detail 111 is treated as LD.
- Alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
- Misaligned op: no RAM request and no stall. misalign_o pulses for 1 cycle. The next wb slot has wb_enable=1, wb_reg_wen=0, wb_mem_ren=0.
- FSM:
  - IDLE: on an aligned memory op, mem_req=1 combinationally. If mem_gnt, go to WAIT; otherwise stay in IDLE and keep requesting.
  - WAIT: mem_req=0. On mem_rvalid, capture wb_* and return to IDLE.
- The earliest rvalid is the cycle after gnt.
- Request fields:
  - mem_addr = {addr[63:3],3'b0}.
  - mem_wstrb = size mask shifted left by addr[2:0].
  - mem_wdata = store_data shifted left by 8*addr[2:0].
  - mem_we = store.
  - All request fields are driven from the EXMEM inputs, which stay stable because stall_o is asserted.
- stall_o = aligned memory op & !(state==WAIT & mem_rvalid). It is combinational, and it drops in the rvalid cycle so upstream advances on that edge.
- wb register update, every clock edge:
  - Stall cycle: wb_enable <= 0 (bubble).
  - Otherwise: wb_* <= current EX fields with wb_enable <= ex_enable.
  - wb_data: loads get the extended lane of mem_rdata (shifted right by 8*addr[2:0], masked, then sign- or zero-extended). Stores get 0. Non-memory ops get ex_alu_result.
- Store: wb_reg_wen is passed through as given (0 in practice). Completion requires rvalid.
- ex_enable=0: no request, no stall, and a bubble propagates (wb_enable=0).
- Back-to-back memory ops: the second op's request may assert in the cycle after the first op's rvalid. There is no overlap; at most one access is outstanding.

Test Plan:
- LW, addr 0x1004, rdata 0x80000001_DEADBEEF, gnt at cycle 0, rvalid at cycle 1 -> mem_addr 0x1000, wstrb 0 / we 0. wb_data 0xFFFFFFFF_80000001, wb_enable high one cycle after rvalid. stall_o high only in cycle 0.
- LBU, addr 0x2007, rdata 0xAB00..00 -> wb_data 0x00000000_000000AB. Same data as LB -> 0xFFFFFFFF_FFFFFFAB.
- SH, addr 0x3002, store_data 0x1234 -> mem_wstrb 0x0C, mem_wdata 0x00000000_12340000, mem_we 1. No wb write.
- LD, addr 0x4004 (misaligned) -> no mem_req, misalign_o pulses once, wb_enable=1 with wb_reg_wen=0, no stall.
- LW with gnt delayed 2 cycles and rvalid 3 cycles after gnt -> stall_o high for 5 cycles, wb_enable=0 during the stall. A following ADD (alu_result 7) reaches wb one cycle after the load.
- Reset asserted in WAIT, then rvalid pulses after release -> state IDLE, all wb_* 0, rvalid ignored, no wb_enable.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-RAM request/response bus between the memory stage and the RAM.
// One access in flight at a time: req/gnt accepts it, rvalid completes it.
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV64I memory stage: issues loads/stores over the RAM bus, extends load data,
// stalls upstream while an access is outstanding and fills the MEM->WB register.
module mem_stage_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_pc_next,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic [RF_SIZE-1:0]    ex_rd,
  input  logic                  ex_reg_wen,
  input  logic                  ex_mem_ren,
  input  logic                  ex_mem_wen,
  input  logic [2:0]            ex_detail,
  input  logic                  ex_enable,
  output logic                  stall_o,
  output logic                  misalign_o,
  mem_stage_lsu_if.master       mem,
  output logic [DATA_WIDTH-1:0] wb_pc,
  output logic [DATA_WIDTH-1:0] wb_pc_next,
  output logic [RF_SIZE-1:0]    wb_rd,
  output logic                  wb_reg_wen,
  output logic                  wb_mem_ren,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_enable
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]            state;
  logic                  is_store;
  logic                  is_load;
  logic                  mem_op;
  logic                  aligned;
  logic                  acc_ok;
  logic                  misaligned;
  logic                  sext;
  logic [1:0]            size;
  logic [2:0]            off;
  logic [5:0]            shamt;
  logic [7:0]            size_mask;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_ext;

  // A store wins if both enables are set
  assign is_store   = ex_mem_wen;
  assign is_load    = ex_mem_ren & ~ex_mem_wen;
  assign mem_op     = ex_enable & (ex_mem_ren | ex_mem_wen);
  assign size       = ex_detail[1:0];
  assign off        = ex_alu_result[2:0];
  assign shamt      = {off, 3'b000};
  assign sext       = ~ex_detail[2];

  always_comb begin
    aligned   = 1'b1;
    size_mask = 8'h01;
    case (size)
      2'd0: begin aligned = 1'b1;             size_mask = 8'h01; end
      2'd1: begin aligned = ~off[0];          size_mask = 8'h03; end
      2'd2: begin aligned = (off[1:0] == 2'b00); size_mask = 8'h0F; end
      default: begin aligned = (off == 3'b000); size_mask = 8'hFF; end
    endcase
  end

  assign acc_ok     = mem_op & aligned;
  assign misaligned = mem_op & ~aligned;

  // Request fields come straight from EXMEM, which is frozen by stall_o
  assign mem.mem_req   = acc_ok & (state == IDLE);
  assign mem.mem_we    = acc_ok & is_store;
  assign mem.mem_addr  = {ex_alu_result[DATA_WIDTH-1:3], 3'b000};
  assign mem.mem_wstrb = is_store ? (size_mask << off) : '0;
  assign mem.mem_wdata = is_store ? (ex_store_data << shamt) : '0;

  // Drops in the rvalid cycle so upstream advances on that same edge
  assign stall_o = acc_ok & ~((state == WAIT) & mem.mem_rvalid);

  assign lane = mem.mem_rdata >> shamt;

  always_comb begin
    load_ext = lane;
    case (size)
      2'd0: load_ext = {{(DATA_WIDTH-8){sext & lane[7]}}, lane[7:0]};
      2'd1: load_ext = {{(DATA_WIDTH-16){sext & lane[15]}}, lane[15:0]};
      2'd2: load_ext = {{(DATA_WIDTH-32){sext & lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (mem.mem_req && mem.mem_gnt) state <= WAIT;
        WAIT: if (mem.mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A stall cycle inserts a bubble; otherwise the EX slot moves into WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_pc      <= '0;
      wb_pc_next <= '0;
      wb_rd      <= '0;
      wb_reg_wen <= 1'b0;
      wb_mem_ren <= 1'b0;
      wb_data    <= '0;
      wb_enable  <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= misaligned;
      if (stall_o) begin
        wb_enable <= 1'b0;
      end else begin
        wb_pc      <= ex_pc;
        wb_pc_next <= ex_pc_next;
        wb_rd      <= ex_rd;
        wb_reg_wen <= ex_reg_wen & ~misaligned;
        wb_mem_ren <= is_load & ~misaligned;
        wb_enable  <= ex_enable;
        if (acc_ok && is_load)
          wb_data <= load_ext;
        else if (mem_op)
          wb_data <= '0;
        else
          wb_data <= ex_alu_result;
      end
    end
  end

endmodule
